// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel output path.
package vga_pkg;
  localparam int VGA_CH_W = 8;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    logic [VGA_CH_W-1:0] blue;
    logic [VGA_CH_W-1:0] green;
    logic [VGA_CH_W-1:0] red;
  } rgb_t;

  // {b,g,r} per bar, index 0 leftmost: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_TBL = {3'b000, 3'b100, 3'b001, 3'b101,
                                         3'b010, 3'b110, 3'b011, 3'b111};
endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with synchronous reset to a fixed pattern; depth 0 is a wire.
module vga_delay_line #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_direct
      logic w_unused;
      assign w_unused = clk ^ reset ^ en;
      assign dout     = din;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] r_sr;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sr <= {DEPTH{RST_VAL}};
        end else if (en) begin
          r_sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign dout = r_sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_pixel_stage.sv
// Registered VGA pixel output stage: sync/de alignment, blanking, channel order.
// Optional 8-bar test pattern when VGA_PIXEL_STAGE_TESTPAT_EN is defined.
module vga_pixel_stage
  import vga_pkg::*;
#(
  parameter int CH_W     = VGA_CH_W,
  parameter int SRC_LAT  = 2,
  parameter bit SYNC_POL = SYNC_ACT_LOW,
  parameter int BAR_W    = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              vid_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [3*CH_W-1:0] color,
  input  logic              swap_rb,
  input  logic              test_mode,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de
);
  localparam logic [2:0] TAIL_RST = {1'b0, !SYNC_POL, !SYNC_POL};

  logic [2:0]          w_tail;  // {vid_on, hsync, vsync} aligned with color
  logic [3*CH_W-1:0]   w_src;
  logic [CH_W-1:0]     r_red, r_green, r_blue;
  logic                r_hs, r_vs, r_de;

  vga_delay_line #(.W(3), .DEPTH(SRC_LAT), .RST_VAL(TAIL_RST)) u_dly (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .din   ({vid_on, hsync_in, vsync_in}),
    .dout  (w_tail)
  );

`ifdef VGA_PIXEL_STAGE_TESTPAT_EN
  localparam int CW = $clog2(8*BAR_W);
  logic [CW-1:0] r_cnt;
  logic [31:0]   w_q;
  logic [2:0]    w_bar, w_bits;

  // counts active pixels of the current line; held at max on overlong lines
  always_ff @(posedge clk) begin
    if (reset)               r_cnt <= '0;
    else if (pix_en) begin
      if (!w_tail[2])        r_cnt <= '0;
      else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_q    = 32'(r_cnt) / 32'(BAR_W);
  assign w_bar  = (w_q > 32'd7) ? 3'd7 : w_q[2:0];
  assign w_bits = BAR_TBL[w_bar];
  assign w_src  = test_mode ? {{CH_W{w_bits[2]}}, {CH_W{w_bits[1]}}, {CH_W{w_bits[0]}}}
                            : color;
`else
  logic w_unused_tm;
  assign w_unused_tm = test_mode;
  assign w_src       = color;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_de    <= 1'b0;
      r_hs    <= !SYNC_POL;
      r_vs    <= !SYNC_POL;
    end else if (pix_en) begin
      r_de <= w_tail[2];
      r_hs <= w_tail[1];
      r_vs <= w_tail[0];
      if (!w_tail[2]) begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end else begin
        r_green <= w_src[2*CH_W-1:CH_W];
        if (swap_rb) begin
          r_red  <= w_src[3*CH_W-1:2*CH_W];
          r_blue <= w_src[CH_W-1:0];
        end else begin
          r_blue <= w_src[3*CH_W-1:2*CH_W];
          r_red  <= w_src[CH_W-1:0];
        end
      end
    end
  end

  assign red   = r_red;
  assign green = r_green;
  assign blue  = r_blue;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign de    = r_de;
endmodule
